// File: rtl/stopwatch_control.sv
// ---------------------------------------------------------------------------
// stopwatch_control
//
// Control stage in front of the stopwatch digit selector. It does four jobs:
//   * It synchronises and debounces the start/stop and lap buttons. Each
//     button then gives a single-cycle press pulse.
//   * It runs the mode FSM (IDLE / RUN / LAP / STOP).
//   * It gates the divider tick to the counter and issues a one-cycle clear.
//   * It freezes the four BCD digits while a lap time is shown.
//
// Ports:
//   CLK, RESET         system clock, synchronous active-high reset
//   CE_IN              divider tick, one CLK cycle wide
//   BTN_SS, BTN_LAP    raw asynchronous active-high buttons
//   CNT1..CNT4         live BCD digits from the counter
//   CE_OUT             tick passed to the counter while RUN or LAP
//   CLR                one-cycle counter clear after the STOP -> IDLE step
//   DISP1..DISP4       digits to the selector (live, or latched during LAP)
//   RUN                high in RUN or LAP
//   LAP_ACT            high in LAP (display frozen)
//
// The FSM state is visible on RUN and LAP_ACT. There is no separate debug
// port because the port list is fixed.
// ---------------------------------------------------------------------------
module stopwatch_control #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE_IN,
  input  logic       BTN_SS,
  input  logic       BTN_LAP,
  input  logic [3:0] CNT1,
  input  logic [3:0] CNT2,
  input  logic [3:0] CNT3,
  input  logic [3:0] CNT4,
  output logic       CE_OUT,
  output logic       CLR,
  output logic [3:0] DISP1,
  output logic [3:0] DISP2,
  output logic [3:0] DISP3,
  output logic [3:0] DISP4,
  output logic       RUN,
  output logic       LAP_ACT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Button bit 0 is start/stop and bit 1 is lap.
  logic [1:0] btn_raw;
  assign btn_raw = {BTN_LAP, BTN_SS};

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q, deb_prev_d;
  logic [DEB_W-1:0] cnt_q [2];
  logic [DEB_W-1:0] cnt_d [2];
  logic [1:0]       press;

  state_e           state_q, state_d;
  logic [15:0]      lat_q, lat_d;   // {digit4, digit3, digit2, digit1}
  logic             clr_q, clr_d;

  // ---------------- input conditioning ----------------
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      // The counter runs only while the synced sample disagrees with the
      // accepted level. Any agreeing cycle restarts the count.
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A press is the rising edge of the debounced level. A release gives no pulse.
  assign press = deb_q & ~deb_prev_q;

  // ---------------- mode FSM ----------------
  always_comb begin
    logic ss_p;
    logic lap_p;
    state_d = state_q;
    lat_d   = lat_q;
    clr_d   = 1'b0;
    ss_p    = press[0];
    // When both buttons pulse together, start/stop wins.
    lap_p   = press[1] & ~press[0];
    unique case (state_q)
      ST_IDLE: begin
        if (ss_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_p) begin
          state_d = ST_STOP;
        end else if (lap_p) begin
          state_d = ST_LAP;
          // These are the digits presented this cycle, before any increment
          // that a concurrent tick causes.
          lat_d   = {CNT4, CNT3, CNT2, CNT1};
        end
      end
      ST_LAP: begin
        if (ss_p)       state_d = ST_STOP;
        else if (lap_p) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      clr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      state_q    <= state_d;
      lat_q      <= lat_d;
      clr_q      <= clr_d;
    end
  end

  // ---------------- outputs ----------------
  // The tick gate uses the current state. A tick on the RUN->STOP edge is
  // passed, and a tick on the STOP->RUN edge is blocked.
  always_comb begin
    RUN     = (state_q == ST_RUN) || (state_q == ST_LAP);
    LAP_ACT = (state_q == ST_LAP);
    CE_OUT  = CE_IN & RUN;
    CLR     = clr_q;
    DISP1   = LAP_ACT ? lat_q[3:0]   : CNT1;
    DISP2   = LAP_ACT ? lat_q[7:4]   : CNT2;
    DISP3   = LAP_ACT ? lat_q[11:8]  : CNT3;
    DISP4   = LAP_ACT ? lat_q[15:12] : CNT4;
  end

endmodule

// File: tb/tb_stopwatch_control.sv
// ---------------------------------------------------------------------------
// Directed bench for stopwatch_control with DEB_CYCLES = 4. A press that is
// first sampled at edge 1 moves the FSM at edge 7. Inputs change 1 ns after a
// rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_stopwatch_control;

  logic       clk;
  logic       rst;
  logic       ce_in;
  logic       btn_ss;
  logic       btn_lap;
  logic [3:0] cnt1, cnt2, cnt3, cnt4;
  logic       ce_out;
  logic       clr;
  logic [3:0] disp1, disp2, disp3, disp4;
  logic       run;
  logic       lap_act;

  int tests_run;
  int tests_failed;

  stopwatch_control #(
    .DEB_CYCLES(4),
    .DEB_W     (16)
  ) dut (
    .CLK    (clk),
    .RESET  (rst),
    .CE_IN  (ce_in),
    .BTN_SS (btn_ss),
    .BTN_LAP(btn_lap),
    .CNT1   (cnt1),
    .CNT2   (cnt2),
    .CNT3   (cnt3),
    .CNT4   (cnt4),
    .CE_OUT (ce_out),
    .CLR    (clr),
    .DISP1  (disp1),
    .DISP2  (disp2),
    .DISP3  (disp3),
    .DISP4  (disp4),
    .RUN    (run),
    .LAP_ACT(lap_act)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_cnt(input logic [15:0] v);
    {cnt4, cnt3, cnt2, cnt1} = v;
  endtask

  // Hold the buttons long enough to register, then release and let the
  // debounced level fall back.
  task automatic press_btn(input logic ss, input logic lap);
    btn_ss  = ss;
    btn_lap = lap;
    repeat (8) step();
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (8) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ce_in = 1'b1;
    set_cnt(16'h4321);
    do_reset();
    tests_run++;
    if ({run, lap_act, clr, ce_out} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got run/lap/clr/ce=%b expected 0000", {run, lap_act, clr, ce_out});
    end
    tests_run++;
    if ({disp4, disp3, disp2, disp1} !== 16'h4321) begin
      tests_failed++;
      $display("FAIL reset_disp: got %h expected 4321", {disp4, disp3, disp2, disp1});
    end
  endtask

  task automatic test_start_latency();
    int   transitions;
    logic prev_run;
    do_reset();
    ce_in       = 1'b1;
    btn_ss      = 1'b1;
    transitions = 0;
    prev_run    = run;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (run !== prev_run) transitions++;
      prev_run = run;
      tests_run++;
      if (run !== (i >= 7) || ce_out !== (i >= 7)) begin
        tests_failed++;
        $display("FAIL start_latency edge %0d: got run=%b ce_out=%b expected %b", i, run, ce_out, (i >= 7));
      end
    end
    btn_ss = 1'b0;
    repeat (8) begin
      step();
      if (run !== prev_run) transitions++;
      prev_run = run;
    end
    tests_run++;
    if (transitions != 1 || run !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_single: got %0d transitions run=%b expected 1 and run=1", transitions, run);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    ce_in = 1'b1;
    for (int c = 0; c < 40; c++) begin
      btn_ss = ((c % 5) < 3);
      step();
      tests_run++;
      if (run !== 1'b0 || ce_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch cycle %0d: got run=%b ce_out=%b expected 0 0", c, run, ce_out);
      end
    end
    btn_ss = 1'b0;
    repeat (8) step();
    tests_run++;
    if (run !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_final: got run=%b expected 0", run);
    end
  endtask

  task automatic test_lap();
    do_reset();
    ce_in = 1'b0;
    set_cnt(16'h4321);
    press_btn(1'b1, 1'b0);
    tests_run++;
    if (run !== 1'b1 || lap_act !== 1'b0 || {disp4, disp3, disp2, disp1} !== 16'h4321) begin
      tests_failed++;
      $display("FAIL lap_live: got run=%b lap=%b disp=%h expected 1 0 4321", run, lap_act, {disp4, disp3, disp2, disp1});
    end
    press_btn(1'b0, 1'b1);
    set_cnt(16'h8765);
    step();
    tests_run++;
    if (lap_act !== 1'b1 || run !== 1'b1 || {disp4, disp3, disp2, disp1} !== 16'h4321) begin
      tests_failed++;
      $display("FAIL lap_frozen: got lap=%b run=%b disp=%h expected 1 1 4321", lap_act, run, {disp4, disp3, disp2, disp1});
    end
    ce_in = 1'b1;
    #1;
    tests_run++;
    if (ce_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL lap_ce_hi: got ce_out=%b expected 1", ce_out);
    end
    ce_in = 1'b0;
    #1;
    tests_run++;
    if (ce_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL lap_ce_lo: got ce_out=%b expected 0", ce_out);
    end
    press_btn(1'b0, 1'b1);
    tests_run++;
    if (lap_act !== 1'b0 || run !== 1'b1 || {disp4, disp3, disp2, disp1} !== 16'h8765) begin
      tests_failed++;
      $display("FAIL lap_release: got lap=%b run=%b disp=%h expected 0 1 8765", lap_act, run, {disp4, disp3, disp2, disp1});
    end
  endtask

  task automatic test_stop_clear();
    do_reset();
    ce_in = 1'b1;
    press_btn(1'b1, 1'b0);
    press_btn(1'b1, 1'b0);
    tests_run++;
    if (run !== 1'b0 || lap_act !== 1'b0 || ce_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_state: got run=%b lap=%b ce_out=%b expected 0 0 0", run, lap_act, ce_out);
    end
    btn_lap = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      tests_run++;
      if (clr !== (i == 7)) begin
        tests_failed++;
        $display("FAIL clr_pulse edge %0d: got clr=%b expected %b", i, clr, (i == 7));
      end
    end
    btn_lap = 1'b0;
    repeat (8) step();
    tests_run++;
    if (clr !== 1'b0 || run !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_after: got clr=%b run=%b expected 0 0", clr, run);
    end
    press_btn(1'b1, 1'b0);
    tests_run++;
    if (run !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_restart: got run=%b expected 1", run);
    end
  endtask

  task automatic test_simultaneous();
    int lap_seen;
    do_reset();
    ce_in = 1'b0;
    set_cnt(16'h9999);
    press_btn(1'b1, 1'b0);
    lap_seen = 0;
    btn_ss   = 1'b1;
    btn_lap  = 1'b1;
    repeat (16) begin
      step();
      if (lap_act === 1'b1) lap_seen++;
      if (lap_seen == 0 && run === 1'b0) begin
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
      end
    end
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (8) begin
      step();
      if (lap_act === 1'b1) lap_seen++;
    end
    tests_run++;
    if (lap_seen != 0 || run !== 1'b0) begin
      tests_failed++;
      $display("FAIL simultaneous: got lap cycles=%0d run=%b expected 0 0", lap_seen, run);
    end
  endtask

  task automatic test_reset_in_lap();
    do_reset();
    ce_in = 1'b1;
    set_cnt(16'h9999);
    press_btn(1'b1, 1'b0);
    press_btn(1'b0, 1'b1);
    set_cnt(16'h3141);
    step();
    tests_run++;
    if (lap_act !== 1'b1 || {disp4, disp3, disp2, disp1} !== 16'h9999) begin
      tests_failed++;
      $display("FAIL pre_reset_lap: got lap=%b disp=%h expected 1 9999", lap_act, {disp4, disp3, disp2, disp1});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if ({run, lap_act, clr, ce_out} !== 4'b0000 || {disp4, disp3, disp2, disp1} !== 16'h3141) begin
      tests_failed++;
      $display("FAIL reset_mid_lap: got run/lap/clr/ce=%b disp=%h expected 0000 3141", {run, lap_act, clr, ce_out}, {disp4, disp3, disp2, disp1});
    end
    press_btn(1'b1, 1'b0);
    set_cnt(16'h2718);
    press_btn(1'b0, 1'b1);
    set_cnt(16'h0000);
    #1;
    tests_run++;
    if (lap_act !== 1'b1 || {disp4, disp3, disp2, disp1} !== 16'h2718) begin
      tests_failed++;
      $display("FAIL later_lap: got lap=%b disp=%h expected 1 2718", lap_act, {disp4, disp3, disp2, disp1});
    end
  endtask

  task automatic test_held_through_reset();
    btn_ss = 1'b1;
    ce_in  = 1'b0;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step();
      tests_run++;
      if (run !== (i >= 7)) begin
        tests_failed++;
        $display("FAIL held_reset edge %0d: got run=%b expected %b", i, run, (i >= 7));
      end
    end
    btn_ss = 1'b0;
    repeat (8) step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    ce_in        = 1'b0;
    btn_ss       = 1'b0;
    btn_lap      = 1'b0;
    set_cnt(16'h0000);
    test_reset();
    test_start_latency();
    test_glitch();
    test_lap();
    test_stop_clear();
    test_simultaneous();
    test_reset_in_lap();
    test_held_through_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
